// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: FSM states, MNT layout, O address layout.
package mac_pkg;

    localparam int DIM          = 8;
    localparam int ROW_W        = 3;
    localparam int FIELD_W      = 4;
    localparam int MNT_W        = 12;
    localparam int MNT_M_LSB    = 8;
    localparam int MNT_N_LSB    = 4;
    localparam int MNT_T_LSB    = 0;

    // addr_o = {row[2:0], half}
    localparam int ADDR_O_W        = 4;
    localparam int ADDR_O_HALF_BIT = 0;
    localparam int ADDR_O_ROW_LSB  = 1;

    // T above this needs two 16-bit O words per result row
    localparam logic [FIELD_W-1:0] HALF_SPLIT = 4'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // A dimension is usable when it lies in 1..DIM
    function automatic logic field_ok(input logic [FIELD_W-1:0] f);
        return (f != 4'd0) && (f <= 4'(DIM));
    endfunction

    // Index of the last row for a dimension of value f (f >= 1)
    function automatic logic [ROW_W-1:0] last_idx(input logic [FIELD_W-1:0] f);
        logic [FIELD_W-1:0] tmp;
        tmp = f - 4'd1;
        return tmp[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Delay line carrying (valid, row) tags alongside the memory read and array pipeline.
module mac_tag_pipe
    import mac_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int IV_TAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [ROW_W-1:0] in_row,
    output logic             i_valid,
    output logic             wr_req,
    output logic [ROW_W-1:0] wr_row
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [ROW_W-1:0] row_q [DEPTH];
    logic [ROW_W-1:0] row_d [DEPTH];

    // Shift every tag one stage deeper each cycle
    always_comb begin
        vld_d    = {vld_q[DEPTH-2:0], in_valid};
        row_d[0] = in_row;
        for (int i = 1; i < DEPTH; i++) begin
            row_d[i] = row_q[i-1];
        end
    end

    // Tag stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                row_q[i] <= 3'd0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                row_q[i] <= row_d[i];
            end
        end
    end

    assign i_valid = vld_q[IV_TAP-1];
    assign wr_req  = vld_q[DEPTH-1];
    assign wr_row  = row_q[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one MxN * NxT multiply: weight rows, input rows, then O-memory writes.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int ARRAY_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MNT_W-1:0]    mnt,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                en_w,
    output logic [ROW_W-1:0]    addr_w,
    output logic                en_i,
    output logic [ROW_W-1:0]    addr_i,
    output logic                w_load,
    output logic [ROW_W-1:0]    w_row,
    output logic                i_valid,
    output logic [FIELD_W-1:0]  n_act,
    output logic [FIELD_W-1:0]  t_act,
    output logic                en_o,
    output logic                rw_o,
    output logic [ADDR_O_W-1:0] addr_o,
    output logic                o_half
);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   cnt_q, cnt_d, row_q, row_d;
    logic               phase_q, phase_d, w2_q, w2_d;
    logic [FIELD_W-1:0] m_q, m_d, n_q, n_d, t_q, t_d;
    logic               err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic               en_w_q, en_w_d, en_i_q, en_i_d, w_load_q, w_load_d;
    logic [ROW_W-1:0]   addr_w_q, addr_w_d, addr_i_q, addr_i_d, w_row_q, w_row_d;
    logic               half2_q, half2_d;
    logic [ROW_W-1:0]   half2_row_q, half2_row_d;
    logic               wr_req_s, last_wr_s;
    logic [ROW_W-1:0]   wr_row_s;
    logic [FIELD_W-1:0] mnt_m_s, mnt_n_s, mnt_t_s;

    assign mnt_m_s = mnt[MNT_M_LSB +: FIELD_W];
    assign mnt_n_s = mnt[MNT_N_LSB +: FIELD_W];
    assign mnt_t_s = mnt[MNT_T_LSB +: FIELD_W];

    mac_tag_pipe #(
        .DEPTH  (RD_LAT + ARRAY_LAT),
        .IV_TAP (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (en_i_q),
        .in_row   (addr_i_q),
        .i_valid  (i_valid),
        .wr_req   (wr_req_s),
        .wr_row   (wr_row_s)
    );

    // Second-half write follows the first-half write of a row when T needs two words
    always_comb begin
        half2_d     = wr_req_s & w2_q;
        half2_row_d = wr_row_s;
        last_wr_s   = (half2_q && (half2_row_q == last_idx(m_q))) ||
                      (wr_req_s && !w2_q && (wr_row_s == last_idx(m_q)));
    end

    // Next-state, counter and next-output logic of the job FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        phase_d  = phase_q;
        w2_d     = w2_q;
        m_d      = m_q;
        n_d      = n_q;
        t_d      = t_q;
        err_d    = err_q;
        en_w_d   = 1'b0;
        addr_w_d = 3'd0;
        en_i_d   = 1'b0;
        addr_i_d = 3'd0;
        w_load_d = en_w_q;
        w_row_d  = en_w_q ? addr_w_q : 3'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = mnt_m_s;
                    n_d   = mnt_n_s;
                    t_d   = mnt_t_s;
                    w2_d  = (mnt_t_s > HALF_SPLIT);
                    if (field_ok(mnt_m_s) && field_ok(mnt_n_s) && field_ok(mnt_t_s)) begin
                        err_d    = 1'b0;
                        state_d  = LOAD_W;
                        cnt_d    = 3'd0;
                        en_w_d   = 1'b1;
                        addr_w_d = 3'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (cnt_q == last_idx(n_q)) begin
                    state_d  = RUN;
                    row_d    = 3'd0;
                    phase_d  = 1'b0;
                    en_i_d   = 1'b1;
                    addr_i_d = 3'd0;
                end else begin
                    cnt_d    = cnt_q + 3'd1;
                    en_w_d   = 1'b1;
                    addr_w_d = cnt_q + 3'd1;
                end
            end
            RUN: begin
                if (w2_q && !phase_q) begin
                    phase_d = 1'b1;
                end else if (row_q == last_idx(m_q)) begin
                    state_d = DRAIN;
                end else begin
                    row_d    = row_q + 3'd1;
                    phase_d  = 1'b0;
                    en_i_d   = 1'b1;
                    addr_i_d = row_q + 3'd1;
                end
            end
            DRAIN: begin
                if (last_wr_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            row_q       <= 3'd0;
            phase_q     <= 1'b0;
            w2_q        <= 1'b0;
            m_q         <= 4'd0;
            n_q         <= 4'd0;
            t_q         <= 4'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            en_w_q      <= 1'b0;
            addr_w_q    <= 3'd0;
            en_i_q      <= 1'b0;
            addr_i_q    <= 3'd0;
            w_load_q    <= 1'b0;
            w_row_q     <= 3'd0;
            half2_q     <= 1'b0;
            half2_row_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            phase_q     <= phase_d;
            w2_q        <= w2_d;
            m_q         <= m_d;
            n_q         <= n_d;
            t_q         <= t_d;
            err_q       <= err_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            en_w_q      <= en_w_d;
            addr_w_q    <= addr_w_d;
            en_i_q      <= en_i_d;
            addr_i_q    <= addr_i_d;
            w_load_q    <= w_load_d;
            w_row_q     <= w_row_d;
            half2_q     <= half2_d;
            half2_row_q <= half2_row_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign en_w   = en_w_q;
    assign addr_w = addr_w_q;
    assign en_i   = en_i_q;
    assign addr_i = addr_i_q;
    assign w_load = w_load_q;
    assign w_row  = w_row_q;
    assign n_act  = n_q;
    assign t_act  = t_q;
    assign en_o   = wr_req_s | half2_q;
    assign rw_o   = en_o;
    assign addr_o = half2_q  ? {half2_row_q, 1'b1} :
                    wr_req_s ? {wr_row_s, 1'b0}    : 4'd0;
    assign o_half = addr_o[ADDR_O_HALF_BIT];

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: jobs push expected timed events, a monitor pops them.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] mnt = 12'd0;
    logic        busy, done, err, en_w, en_i, w_load, i_valid, en_o, rw_o, o_half;
    logic [2:0]  addr_w, addr_i, w_row;
    logic [3:0]  n_act, t_act, addr_o;
    logic [30:0] all_outs;

    mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mnt(mnt),
        .busy(busy), .done(done), .err(err),
        .en_w(en_w), .addr_w(addr_w), .en_i(en_i), .addr_i(addr_i),
        .w_load(w_load), .w_row(w_row), .i_valid(i_valid),
        .n_act(n_act), .t_act(t_act),
        .en_o(en_o), .rw_o(rw_o), .addr_o(addr_o), .o_half(o_half)
    );

    assign all_outs = {busy, done, err, en_w, addr_w, en_i, addr_i, w_load, w_row,
                       i_valid, n_act, t_act, en_o, rw_o, addr_o, o_half};

    always #5 clk = ~clk;

    localparam int K_W = 0, K_WL = 1, K_I = 2, K_IV = 3, K_O = 4, K_D = 5;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Pop the oldest expected event of this kind and compare its cycle and value
    task automatic check_ev(input int kind, input int val, input string nm);
        int idx;
        idx = -1;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].kind == kind) idx = i;
        end
        tests++;
        if (idx < 0) begin
            fails++;
            $display("FAIL %s: unexpected event at cycle %0d value %0d", nm, cyc, val);
        end else begin
            if (exp_q[idx].cyc != cyc || exp_q[idx].val != val) begin
                fails++;
                $display("FAIL %s: got cycle %0d value %0d, want cycle %0d value %0d",
                         nm, cyc, val, exp_q[idx].cyc, exp_q[idx].val);
            end
            exp_q.delete(idx);
        end
    endtask

    // Monitor: sample on the falling edge, pop and compare whenever the DUT shows an event
    always @(negedge clk) begin
        if (!rst) begin
            if (busy)    busy_cnt++;
            if (en_w)    check_ev(K_W, int'(addr_w), "en_w");
            if (w_load)  check_ev(K_WL, int'(w_row), "w_load");
            if (en_i)    check_ev(K_I, int'(addr_i), "en_i");
            if (i_valid) check_ev(K_IV, 0, "i_valid");
            if (en_o)    check_ev(K_O, int'(addr_o) * 4 + int'(rw_o) * 2 + int'(o_half), "o_write");
            if (done)    check_ev(K_D, int'(err), "done");
        end
    end

    function automatic void push(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    // Expected event timeline for a job started with base cycle s; returns done offset
    function automatic int push_job(input int s, input int m, input int n, input int t);
        int w, ri;
        if (m < 1 || m > 8 || n < 1 || n > 8 || t < 1 || t > 8) begin
            push(K_D, s + 1, 1);
            return 1;
        end
        w = (t > 4) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            push(K_W, s + 1 + k, k);
            push(K_WL, s + 2 + k, k);
        end
        for (int r = 0; r < m; r++) begin
            ri = s + n + 1 + r * w;
            push(K_I, ri, r);
            push(K_IV, ri + 1, 0);
            for (int h = 0; h < w; h++) begin
                push(K_O, ri + 3 + h, (r * 2 + h) * 4 + 2 + h);
            end
        end
        push(K_D, s + n + m * w + 4, 0);
        return n + m * w + 4;
    endfunction

    task automatic run_job(input int m, input int n, input int t, input bit hold);
        int  s, dr;
        bit  ok;
        ok = (m >= 1 && m <= 8 && n >= 1 && n <= 8 && t >= 1 && t <= 8);
        @(negedge clk);
        s        = cyc;
        busy_cnt = 0;
        start    = 1'b1;
        mnt      = {4'(m), 4'(n), 4'(t)};
        dr       = push_job(s, m, n, t);
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (ok) begin
            check_val("n_act", int'(n_act), n);
            check_val("t_act", int'(t_act), t);
            check_val("err_cleared", int'(err), 0);
        end
        while (cyc < s + dr) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("missing_events", exp_q.size(), 0);
        check_val("busy_cycles", busy_cnt, dr);
        check_val("busy_idle", int'(busy), 0);
        check_val("err_held", int'(err), ok ? 0 : 1);
    endtask

    // Start a 2,2,8 job and hit it with async reset in its fourth cycle
    task automatic reset_mid_run();
        int s, dr;
        @(negedge clk);
        s     = cyc;
        start = 1'b1;
        mnt   = {4'd2, 4'd2, 4'd8};
        dr    = push_job(s, 2, 2, 8);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_val("async_reset_outs", int'(all_outs), 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (dr + 4) @(negedge clk);
        check_val("no_done_after_abort", exp_q.size() + int'(busy), 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_val("reset_outs", int'(all_outs), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_outs", int'(all_outs), 0);

        run_job(2, 2, 8, 1'b0);   // W=2 basic
        run_job(3, 1, 3, 1'b0);   // W=1, single weight row
        run_job(8, 8, 8, 1'b0);   // full size
        run_job(0, 3, 3, 1'b0);   // invalid M=0
        run_job(9, 1, 1, 1'b0);   // invalid M=9
        run_job(1, 8, 4, 1'b0);   // valid start clears err; T=4 stays one word
        run_job(2, 1, 5, 1'b0);   // T=5 needs two words
        run_job(3, 2, 5, 1'b1);   // start held high throughout
        reset_mid_run();
        run_job(2, 2, 8, 1'b0);   // fresh run after abort

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
